// File: rtl/instr_fetcher.sv
// -----------------------------------------------------------------------------
// instr_fetcher
//   Front-end instruction fetcher. Issues one word read at a time, collects the
//   returned words with their PCs into a small circular queue and presents the
//   queue head to decode. A ROB flush empties the queue and redirects the PC;
//   a response that was still in flight at flush time is dropped on arrival.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   rdy               global enable; low freezes all state (no request issued)
//   out_mem_req       one-cycle fetch request pulse
//   out_mem_addr      fetch address, valid with out_mem_req
//   in_mem_valid      one-cycle response strobe
//   in_mem_data       returned instruction word
//   out_decode_valid  queue head holds an instruction
//   out_decode_instr  queue-head instruction (0 when empty)
//   out_decode_pc     queue-head PC (0 when empty)
//   in_decode_ready   decode consumes the head this cycle
//   in_rob_flush      redirect strobe
//   in_rob_newpc      redirect target
//
// QUEUE_DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module instr_fetcher #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_data,
  output logic        out_decode_valid,
  output logic [31:0] out_decode_instr,
  output logic [31:0] out_decode_pc,
  input  logic        in_decode_ready,
  input  logic        in_rob_flush,
  input  logic [31:0] in_rob_newpc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state_r;
  logic [31:0]      pc_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             out_mem_req_r;
  logic [31:0]      out_mem_addr_r;
  logic [31:0]      instr_q_r [QUEUE_DEPTH];
  logic [31:0]      pc_q_r    [QUEUE_DEPTH];

  logic has_head_s;
  logic issue_s;
  logic push_s;
  logic pop_s;

  // A flush masks every other event in the cycle it arrives.
  assign has_head_s = (count_r != {CNT_W{1'b0}});
  assign issue_s    = rdy && !in_rob_flush && (state_r == IDLE) && (count_r < DEPTH_C);
  assign push_s     = rdy && !in_rob_flush && (state_r == WAIT) && in_mem_valid;
  assign pop_s      = rdy && !in_rob_flush && has_head_s && in_decode_ready;

  assign out_mem_req      = out_mem_req_r;
  assign out_mem_addr     = out_mem_addr_r;
  assign out_decode_valid = has_head_s;
  // Head is masked when empty so reset and post-flush views read as zero.
  assign out_decode_instr = has_head_s ? instr_q_r[head_r] : 32'h0000_0000;
  assign out_decode_pc    = has_head_s ? pc_q_r[head_r]    : 32'h0000_0000;

  // Fetch FSM, PC, queue pointers/count and the request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      pc_r           <= RESET_PC;
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      count_r        <= {CNT_W{1'b0}};
      out_mem_req_r  <= 1'b0;
      out_mem_addr_r <= 32'h0000_0000;
    end else begin
      // The request is a pulse; it also drops while rdy is low, which is why
      // it sits outside the enable below.
      out_mem_req_r <= issue_s;
      if (rdy) begin
        if (issue_s) begin
          out_mem_addr_r <= pc_r;
        end else begin
          out_mem_addr_r <= out_mem_addr_r;
        end
        if (in_rob_flush) begin
          pc_r    <= in_rob_newpc;
          head_r  <= {PTR_W{1'b0}};
          tail_r  <= {PTR_W{1'b0}};
          count_r <= {CNT_W{1'b0}};
          // A request still in flight must be absorbed in DROP; if its
          // response lands this very cycle nothing is outstanding any more.
          case (state_r)
            WAIT:    state_r <= in_mem_valid ? IDLE : DROP;
            DROP:    state_r <= in_mem_valid ? IDLE : DROP;
            default: state_r <= IDLE;
          endcase
        end else begin
          if (push_s) begin
            tail_r <= tail_r + PTR_W'(1'b1);
            pc_r   <= pc_r + 32'd4;
          end
          if (pop_s) begin
            head_r <= head_r + PTR_W'(1'b1);
          end
          count_r <= count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
          case (state_r)
            IDLE:    state_r <= issue_s ? WAIT : IDLE;
            WAIT:    state_r <= in_mem_valid ? IDLE : WAIT;
            DROP:    state_r <= in_mem_valid ? IDLE : DROP;
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  // Queue storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_q_r[tail_r] <= in_mem_data;
      pc_q_r[tail_r]    <= pc_r;
    end
  end

endmodule
